// File: rtl/fft64_frame_feeder_if.sv
// Sample-stream bundle for fft64_frame_feeder: upstream valid/ready input side
// plus the burst output that drives valid_a/ar/ai of fft64/ifft64.
interface fft64_frame_feeder_if #(
   parameter int WIDTH = 11
);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] dr;
   logic [WIDTH-1:0] di;
   logic             valid_o;
   logic [WIDTH-1:0] xr;
   logic [WIDTH-1:0] xi;
   logic             frame_o;

   modport master (
      output valid_i, dr, di,
      input  ready_o, valid_o, xr, xi, frame_o
   );

   modport slave (
      input  valid_i, dr, di,
      output ready_o, valid_o, xr, xi, frame_o
   );
endinterface

// File: rtl/fft64_frame_feeder.sv
// Ping-pong 2x64 frame buffer emitting unbroken 64-cycle bursts with a minimum idle gap.
// Optional macro FEEDER_BITREV_EN: burst read in bit-reversed index order.
module fft64_frame_feeder #(
   parameter int WIDTH = 11,
   parameter int GAP   = 0
) (
   input  logic                 CLK,
   input  logic                 RST,
   fft64_frame_feeder_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

   // GAP state also counts the IDLE cycle that follows it, so it lasts GAP-1 cycles
   localparam logic [7:0] GAP_LAST = 8'((GAP > 1) ? GAP - 1 : 1);

   logic [WIDTH-1:0] r_mem_r [0:127];
   logic [WIDTH-1:0] r_mem_i [0:127];

   state_t           r_state;
   logic [1:0]       r_full;
   logic             r_wr_bank;
   logic [5:0]       r_wr_cnt;
   logic             r_rd_bank;
   logic [5:0]       r_rd_cnt;
   logic [7:0]       r_gap_cnt;
   logic             r_valid;
   logic             r_frame;
   logic [WIDTH-1:0] r_xr;
   logic [WIDTH-1:0] r_xi;

   logic             w_ready;
   logic             w_wr_en;
   logic             w_wr_last;
   logic             w_rd_last;
   logic [1:0]       w_full_set;
   logic [1:0]       w_full_clr;
   logic [5:0]       w_rd_idx;
   logic [6:0]       w_rd_addr;

   assign w_ready    = !RST && !r_full[r_wr_bank];
   assign w_wr_en    = bus.valid_i && w_ready;
   assign w_wr_last  = w_wr_en && (r_wr_cnt == 6'd63);
   assign w_rd_last  = (r_state == S_BURST) && (r_rd_cnt == 6'd63);
   assign w_full_set = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;
   assign w_full_clr = w_rd_last ? (2'b01 << r_rd_bank) : 2'b00;

   always_comb begin
      w_rd_idx = r_rd_cnt;
`ifdef FEEDER_BITREV_EN
      for (int b = 0; b < 6; b++) w_rd_idx[b] = r_rd_cnt[5-b];
`endif
   end

   assign w_rd_addr = {r_rd_bank, w_rd_idx};

   always_ff @(posedge CLK) begin
      if (w_wr_en) begin
         r_mem_r[{r_wr_bank, r_wr_cnt}] <= bus.dr;
         r_mem_i[{r_wr_bank, r_wr_cnt}] <= bus.di;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_full    <= 2'b00;
         r_wr_bank <= 1'b0;
         r_wr_cnt  <= 6'd0;
         r_rd_bank <= 1'b0;
         r_rd_cnt  <= 6'd0;
         r_gap_cnt <= 8'd0;
         r_valid   <= 1'b0;
         r_frame   <= 1'b0;
         r_xr      <= '0;
         r_xi      <= '0;
      end else begin
         // set and clear always target different banks, so both apply
         r_full <= (r_full & ~w_full_clr) | w_full_set;
         if (w_wr_en) begin
            r_wr_cnt <= r_wr_cnt + 6'd1;
            if (r_wr_cnt == 6'd63) r_wr_bank <= ~r_wr_bank;
         end
         r_valid <= 1'b0;
         r_frame <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_full[r_rd_bank]) begin
                  r_state  <= S_BURST;
                  r_rd_cnt <= 6'd0;
               end
            end
            S_BURST: begin
               r_valid  <= 1'b1;
               r_frame  <= (r_rd_cnt == 6'd0);
               r_xr     <= r_mem_r[w_rd_addr];
               r_xi     <= r_mem_i[w_rd_addr];
               r_rd_cnt <= r_rd_cnt + 6'd1;
               if (r_rd_cnt == 6'd63) begin
                  r_rd_bank <= ~r_rd_bank;
                  if (GAP > 0) begin
                     r_state   <= S_GAP;
                     r_gap_cnt <= 8'd1;
                  end else if (r_full[~r_rd_bank]) begin
                     r_state <= S_BURST;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_LAST) r_state <= S_IDLE;
               else                       r_gap_cnt <= r_gap_cnt + 8'd1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ready_o = w_ready;
   assign bus.valid_o = r_valid;
   assign bus.frame_o = r_frame;
   assign bus.xr      = r_xr;
   assign bus.xi      = r_xi;
endmodule

// File: tb/tb_fft64_frame_feeder.sv
// Directed bench for fft64_frame_feeder: one DUT with gap=0, one with gap=5.
module tb_fft64_frame_feeder;
   localparam int W = 11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   fft64_frame_feeder_if #(.WIDTH(W)) bus  ();
   fft64_frame_feeder_if #(.WIDTH(W)) bus5 ();

   fft64_frame_feeder #(.WIDTH(W), .GAP(0)) u_dut  (.CLK(clk), .RST(rst), .bus(bus.slave));
   fft64_frame_feeder #(.WIDTH(W), .GAP(5)) u_dut5 (.CLK(clk), .RST(rst), .bus(bus5.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [W-1:0] q_d[$], q_i[$], q5_d[$];
   logic         q_f[$];
   int           q_c[$], q5_c[$];

   always @(negedge clk) begin
      if (bus.valid_o) begin
         q_d.push_back(bus.xr); q_i.push_back(bus.xi);
         q_f.push_back(bus.frame_o); q_c.push_back(cyc);
      end
      if (bus5.valid_o) begin
         q5_d.push_back(bus5.xr); q5_c.push_back(cyc);
      end
   end

   // burst position j -> sample index it should carry
   function automatic int exp_idx(input int j);
      int r;
      r = j % 64;
`ifdef FEEDER_BITREV_EN
      begin
         int t;
         t = 0;
         for (int b = 0; b < 6; b++) if (r & (1 << b)) t |= (1 << (5 - b));
         r = t;
      end
`endif
      return (j / 64) * 64 + r;
   endfunction

   task automatic clear_q();
      q_d.delete(); q_i.delete(); q_f.delete(); q_c.delete();
      q5_d.delete(); q5_c.delete();
   endtask

   // called and returns at posedge+1; sample base+k carries dr=base+k, di=-(base+k)
   task automatic feed(input bit sel, input int base, input int n, input bit rnd,
                       output int hs_last, output int first_stall);
      int k, t;
      bit v;
      k = 0; t = 0; hs_last = -1; first_stall = -1;
      while (k < n && t < 2000) begin
         v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (sel) begin
            bus5.valid_i = v; bus5.dr = W'(base + k); bus5.di = W'(-(base + k));
         end else begin
            bus.valid_i = v; bus.dr = W'(base + k); bus.di = W'(-(base + k));
         end
         if (v && (sel ? bus5.ready_o : bus.ready_o)) begin
            k++; hs_last = cyc + 1;
         end else if (v && first_stall < 0) begin
            first_stall = k;
         end
         @(posedge clk); #1; t++;
      end
      bus.valid_i = 1'b0; bus5.valid_i = 1'b0;
      if (k < n) begin
         errors++; checks++;
         $display("FAIL feed_timeout: accepted %0d want %0d", k, n);
      end
   endtask

   task automatic wait_out(input bit sel, input int n, input int budget);
      int t;
      t = 0;
      while (((sel ? q5_c.size() : q_c.size()) < n) && t < budget) begin
         @(posedge clk); #1; t++;
      end
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.valid_i = 1'b1; bus.dr = '0; bus.di = '0;
      bus5.valid_i = 1'b0; bus5.dr = '0; bus5.di = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o: got %b want 0", bus.valid_o); end
      checks++; if (bus.frame_o !== 1'b0) begin errors++; $display("FAIL reset_frame_o: got %b want 0", bus.frame_o); end
      checks++; if (bus.xr !== W'(0)) begin errors++; $display("FAIL reset_xr: got %0d want 0", bus.xr); end
      checks++; if (bus.xi !== W'(0)) begin errors++; $display("FAIL reset_xi: got %0d want 0", bus.xi); end
      checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b want 0", bus.ready_o); end
      checks++; if (bus5.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o_g5: got %b want 0", bus5.valid_o); end
      bus.valid_i = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", bus.ready_o); end
      @(posedge clk); #1;
   endtask

   task automatic test_single_frame(input bit rnd, input string nm);
      int hs, st, n;
      clear_q();
      feed(1'b0, 0, 64, rnd, hs, st);
      wait_out(1'b0, 64, 300);
      n = q_c.size();
      checks++; if (n != 64) begin errors++; $display("FAIL %s_count: got %0d want 64", nm, n); end
      if (n > 0) begin
         checks++; if (q_c[0] != hs + 2) begin errors++; $display("FAIL %s_latency: first valid cycle %0d want %0d", nm, q_c[0], hs + 2); end
      end
      for (int j = 0; j < n && j < 64; j++) begin
         checks++;
         if (q_c[j] != q_c[0] + j || q_d[j] !== W'(exp_idx(j)) || q_i[j] !== W'(-exp_idx(j)) || q_f[j] !== (j == 0)) begin
            errors++;
            $display("FAIL %s_sample%0d: got cyc=%0d xr=%0d xi=%0d fr=%b want cyc=%0d xr=%0d xi=%0d fr=%b",
                     nm, j, q_c[j], q_d[j], q_i[j], q_f[j], q_c[0] + j, exp_idx(j), W'(-exp_idx(j)), j == 0);
         end
      end
   endtask

   task automatic test_back_to_back();
      int hs, st, n;
      clear_q();
      feed(1'b0, 0, 192, 1'b0, hs, st);
      wait_out(1'b0, 192, 500);
      n = q_c.size();
      checks++; if (st != 128) begin errors++; $display("FAIL b2b_stall_index: got %0d want 128", st); end
      checks++; if (n != 192) begin errors++; $display("FAIL b2b_count: got %0d want 192", n); end
      for (int j = 0; j < n && j < 192; j++) begin
         checks++;
         if (q_d[j] !== W'(exp_idx(j)) || q_f[j] !== (j % 64 == 0) || (j < 128 && q_c[j] != q_c[0] + j)) begin
            errors++;
            $display("FAIL b2b_sample%0d: got xr=%0d fr=%b cyc=%0d want xr=%0d fr=%b", j, q_d[j], q_f[j], q_c[j], exp_idx(j), j % 64 == 0);
         end
      end
   endtask

   task automatic test_gap();
      int hs, st, n;
      clear_q();
      feed(1'b1, 0, 128, 1'b0, hs, st);
      wait_out(1'b1, 128, 500);
      n = q5_c.size();
      checks++; if (n != 128) begin errors++; $display("FAIL gap_count: got %0d want 128", n); end
      if (n >= 65) begin
         checks++;
         if (q5_c[64] - q5_c[63] - 1 != 5) begin
            errors++; $display("FAIL gap_idle_cycles: got %0d want 5", q5_c[64] - q5_c[63] - 1);
         end
      end
      for (int j = 0; j < n && j < 128; j++) begin
         checks++;
         if (q5_d[j] !== W'(exp_idx(j)) || q5_c[j] != q5_c[(j / 64) * 64] + (j % 64)) begin
            errors++; $display("FAIL gap_sample%0d: got xr=%0d cyc=%0d want xr=%0d", j, q5_d[j], q5_c[j], exp_idx(j));
         end
      end
   endtask

   task automatic test_reset_mid();
      int k, t, hs, st, n;
      bit fired;
      k = 0; t = 0; fired = 1'b0;
      clear_q();
      while (!fired && t < 400) begin
         bus.valid_i = 1'b1; bus.dr = W'(k); bus.di = W'(-k);
         if (bus.ready_o) k++;
         @(posedge clk); #1; t++;
         if (q_c.size() == 21) fired = 1'b1;
      end
      checks++; if (!fired) begin errors++; $display("FAIL rstmid_no_burst: outputs %0d want 21", q_c.size()); end
      rst = 1'b1; bus.valid_i = 1'b0;
      #1;
      checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_rst: got %b want 0", bus.ready_o); end
      @(posedge clk); #1;
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid_abort: got %b want 0", bus.valid_o); end
      rst = 1'b0;
      #1;
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %b want 1", bus.ready_o); end
      clear_q();
      feed(1'b0, 100, 64, 1'b0, hs, st);
      wait_out(1'b0, 64, 300);
      repeat (100) @(posedge clk);
      #1;
      n = q_c.size();
      checks++; if (n != 64) begin errors++; $display("FAIL rstmid_count: got %0d want 64", n); end
      for (int j = 0; j < n && j < 64; j++) begin
         checks++;
         if (q_d[j] !== W'(100 + exp_idx(j)) || q_i[j] !== W'(-(100 + exp_idx(j))) || q_f[j] !== (j == 0)) begin
            errors++; $display("FAIL rstmid_sample%0d: got xr=%0d xi=%0d fr=%b want xr=%0d", j, q_d[j], q_i[j], q_f[j], 100 + exp_idx(j));
         end
      end
   endtask

   task automatic test_order();
      int hs, st, n;
      int exp_head [5];
`ifdef FEEDER_BITREV_EN
      exp_head = '{0, 32, 16, 48, 8};
`else
      exp_head = '{0, 1, 2, 3, 4};
`endif
      clear_q();
      feed(1'b0, 0, 64, 1'b0, hs, st);
      wait_out(1'b0, 64, 300);
      n = q_d.size();
      checks++; if (n != 64) begin errors++; $display("FAIL order_count: got %0d want 64", n); end
      for (int j = 0; j < 5 && j < n; j++) begin
         checks++; if (q_d[j] !== W'(exp_head[j])) begin errors++; $display("FAIL order_head%0d: got %0d want %0d", j, q_d[j], exp_head[j]); end
      end
      if (n == 64) begin
         checks++; if (q_d[63] !== W'(63)) begin errors++; $display("FAIL order_last: got %0d want 63", q_d[63]); end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame(1'b0, "basic");
      test_back_to_back();
      test_gap();
      test_single_frame(1'b1, "random");
      test_reset_mid();
      test_order();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
